// File: rtl/spike_rate_decoder_if.sv
// ---------------------------------------------------------------------------
// spike_rate_decoder_if
//   Result channel of the spike rate decoder. It is a one-word valid/ready
//   stream carrying a decoded window result.
//
//   Signals:
//     rate_out  [CNT_W] spike count of the completed window
//     isi_out   [ISI_W] last inter-spike interval at or before the window end
//     rate_sat  [1]     spike count saturated in that window
//     out_valid [1]     a result word is held
//     out_ready [1]     consumer takes the word when out_valid & out_ready
//
//   Modports:
//     master - result producer (the decoder)
//     slave  - result consumer
// ---------------------------------------------------------------------------
interface spike_rate_decoder_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned ISI_W = 8
);
    logic [CNT_W-1:0] rate_out;
    logic [ISI_W-1:0] isi_out;
    logic             rate_sat;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output rate_out, isi_out, rate_sat, out_valid,
        input  out_ready
    );

    modport slave (
        input  rate_out, isi_out, rate_sat, out_valid,
        output out_ready
    );
endinterface

// File: rtl/spike_rate_decoder.sv
// ---------------------------------------------------------------------------
// spike_rate_decoder
//   Decodes a 1-bit LIF spike train into a rate: the number of spikes seen in
//   a programmable window of cycles. It also reports the most recent
//   inter-spike interval. Each window result goes through a one-entry
//   valid/ready buffer. A result that arrives while the buffer is still full
//   is dropped, and the sticky overflow flag is set.
//
//   Ports:
//     clk        in   rising-edge clock
//     reset      in   asynchronous, active-high reset
//     enable     in   run decoding; 0 aborts the current window
//     spike_in   in   spike from the neuron, sampled every edge
//     window_len in   [WIN_W] window length, latched at each window start
//     overflow   out  sticky: a window result was dropped (buffer full)
//     res        if   result channel (master): rate_out, isi_out, rate_sat,
//                     out_valid, out_ready
// ---------------------------------------------------------------------------
module spike_rate_decoder #(
    parameter int unsigned WIN_W = 8,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned ISI_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 spike_in,
    input  logic [WIN_W-1:0]     window_len,
    output logic                 overflow,
    spike_rate_decoder_if.master res
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ISI_W-1:0] ISI_MAX = '1;

    typedef enum logic {IDLE, COUNT} state_t;

    state_t           state;
    logic [WIN_W-1:0] len;
    logic [WIN_W-1:0] cyc;
    logic [CNT_W-1:0] spk;
    logic             sat;
    logic [ISI_W-1:0] isi_cnt;
    logic [ISI_W-1:0] last_isi;
    logic             has_prev;

    // Values the window registers take after this cycle's spike is applied.
    // The window-end result is built from these values, so a spike in the
    // last cycle is included.
    logic [CNT_W-1:0] spk_nxt;
    logic             sat_nxt;
    logic [ISI_W-1:0] isi_nxt;
    logic [ISI_W-1:0] last_isi_nxt;
    logic             has_prev_nxt;
    logic             win_end;
    logic             load_ok;

    // NOTE: every signal gets a default at the top of the block, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        spk_nxt      = spk;
        sat_nxt      = sat;
        isi_nxt      = (isi_cnt == ISI_MAX) ? isi_cnt : isi_cnt + 1'b1;
        last_isi_nxt = last_isi;
        has_prev_nxt = has_prev;
        if (spike_in) begin
            if (spk == CNT_MAX) sat_nxt = 1'b1;
            else                spk_nxt = spk + 1'b1;
            // The interval closes on the counter value from before this edge.
            if (has_prev) last_isi_nxt = isi_cnt;
            isi_nxt      = ISI_W'(1);
            has_prev_nxt = 1'b1;
        end
        win_end = (state == COUNT) && enable && (cyc == len - 1'b1);
        load_ok = !res.out_valid || res.out_ready;
    end

    // NOTE: all state is updated with non-blocking assignments. Every
    // register then sees the values from before the edge, whatever order the
    // statements are written in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            len           <= '0;
            cyc           <= '0;
            spk           <= '0;
            sat           <= 1'b0;
            isi_cnt       <= '0;
            last_isi      <= '0;
            has_prev      <= 1'b0;
            overflow      <= 1'b0;
            res.rate_out  <= '0;
            res.isi_out   <= '0;
            res.rate_sat  <= 1'b0;
            res.out_valid <= 1'b0;
        end else begin
            // A handshake empties the buffer. A load later in this block
            // overrides that, because the last assignment wins.
            if (res.out_valid && res.out_ready) res.out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable && window_len != '0) begin
                        state    <= COUNT;
                        len      <= window_len;
                        cyc      <= '0;
                        spk      <= '0;
                        sat      <= 1'b0;
                        isi_cnt  <= '0;
                        last_isi <= '0;
                        has_prev <= 1'b0;
                    end
                end

                COUNT: begin
                    if (!enable) begin
                        // Abort: the partial window leaves no trace.
                        state <= IDLE;
                    end else begin
                        // ISI tracking carries across back-to-back windows.
                        isi_cnt  <= isi_nxt;
                        last_isi <= last_isi_nxt;
                        has_prev <= has_prev_nxt;
                        if (win_end) begin
                            if (load_ok) begin
                                res.out_valid <= 1'b1;
                                res.rate_out  <= spk_nxt;
                                res.isi_out   <= last_isi_nxt;
                                res.rate_sat  <= sat_nxt;
                            end else begin
                                overflow <= 1'b1;
                            end
                            if (window_len != '0) begin
                                len <= window_len;
                                cyc <= '0;
                                spk <= '0;
                                sat <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cyc <= cyc + 1'b1;
                            spk <= spk_nxt;
                            sat <= sat_nxt;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spike_rate_decoder.sv
// ---------------------------------------------------------------------------
// tb_spike_rate_decoder
//   Drives the spike rate decoder with directed scenarios and a randomized
//   stretch. A reference model works from absolute spike times and window
//   boundaries. The bench uses narrow count and ISI fields so that both
//   saturate.
// ---------------------------------------------------------------------------
module tb_spike_rate_decoder;
    localparam int unsigned WIN_W = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ISI_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int ISI_MAX = (1 << ISI_W) - 1;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             spike_in;
    logic [WIN_W-1:0] window_len;
    logic             overflow;

    spike_rate_decoder_if #(.CNT_W(CNT_W), .ISI_W(ISI_W)) bus ();

    spike_rate_decoder #(.WIN_W(WIN_W), .CNT_W(CNT_W), .ISI_W(ISI_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .spike_in   (spike_in),
        .window_len (window_len),
        .overflow   (overflow),
        .res        (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: windows are spans of absolute cycle numbers, and ISIs
    // are differences between absolute spike times.
    int now;
    bit m_active;
    int m_start;
    int m_len;
    int m_spikes;
    bit m_seen_spike;
    int m_prev_t;
    int m_last_isi;
    bit exp_valid;
    int exp_rate;
    int exp_isi;
    bit exp_sat;
    bit exp_ovf;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(string tag);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(exp_valid));
        check({tag, ".rate_out"},  32'(bus.rate_out),  32'(exp_rate));
        check({tag, ".isi_out"},   32'(bus.isi_out),   32'(exp_isi));
        check({tag, ".rate_sat"},  32'(bus.rate_sat),  32'(exp_sat));
        check({tag, ".overflow"},  32'(overflow),      32'(exp_ovf));
    endtask

    task automatic model_reset();
        m_active     = 1'b0;
        m_seen_spike = 1'b0;
        m_spikes     = 0;
        m_last_isi   = 0;
        exp_valid    = 1'b0;
        exp_rate     = 0;
        exp_isi      = 0;
        exp_sat      = 1'b0;
        exp_ovf      = 1'b0;
    endtask

    task automatic start_window(int first_cycle, int length, bit fresh);
        m_active = 1'b1;
        m_start  = first_cycle;
        m_len    = length;
        m_spikes = 0;
        if (fresh) begin
            m_seen_spike = 1'b0;
            m_last_isi   = 0;
        end
    endtask

    // Apply the current inputs for one clock edge, predict the outcome, and
    // compare just after the edge.
    task automatic tick(string tag);
        bit res_v = 1'b0;
        int r_rate = 0;
        int r_isi = 0;
        bit r_sat = 1'b0;
        if (!m_active) begin
            if (enable && window_len != 0) start_window(now + 1, int'(window_len), 1'b1);
        end else if (!enable) begin
            m_active = 1'b0;
        end else begin
            if (spike_in) begin
                m_spikes++;
                if (m_seen_spike)
                    m_last_isi = (now - m_prev_t > ISI_MAX) ? ISI_MAX : now - m_prev_t;
                m_prev_t     = now;
                m_seen_spike = 1'b1;
            end
            if (now == m_start + m_len - 1) begin
                res_v  = 1'b1;
                r_rate = (m_spikes > CNT_MAX) ? CNT_MAX : m_spikes;
                r_sat  = (m_spikes > CNT_MAX);
                r_isi  = m_last_isi;
                if (window_len != 0) start_window(now + 1, int'(window_len), 1'b0);
                else                 m_active = 1'b0;
            end
        end
        if (res_v) begin
            if (!exp_valid || bus.out_ready) begin
                exp_valid = 1'b1;
                exp_rate  = r_rate;
                exp_isi   = r_isi;
                exp_sat   = r_sat;
            end else begin
                exp_ovf = 1'b1;
            end
        end else if (exp_valid && bus.out_ready) begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        now++;
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        now += 2;
        #1;
        reset = 1'b0;
        check_outputs("reset");
    endtask

    task automatic idle(int n, string tag);
        enable   = 1'b0;
        spike_in = 1'b0;
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        now           = 0;
        reset         = 1'b1;
        enable        = 1'b0;
        spike_in      = 1'b0;
        window_len    = '0;
        bus.out_ready = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Window of 8 with spikes at window cycles 1, 3 and 6.
        bus.out_ready = 1'b1;
        window_len    = 8'd8;
        enable        = 1'b1;
        tick("t2_start");
        for (int c = 0; c < 8; c++) begin
            spike_in = (c == 1 || c == 3 || c == 6);
            tick("t2_win");
            if (c == 6) check("t2_not_early", 32'(bus.out_valid), 32'd0);
        end
        check("t2_valid", 32'(bus.out_valid), 32'd1);
        check("t2_rate",  32'(bus.rate_out),  32'd3);
        check("t2_isi",   32'(bus.isi_out),   32'd3);
        check("t2_sat",   32'(bus.rate_sat),  32'd0);
        spike_in = 1'b0;
        tick("t2_next");

        // Abort at window cycle 5 of 10, then re-enable with one spike.
        idle(3, "t5_idle");
        window_len = 8'd10;
        enable     = 1'b1;
        tick("t5_start");
        for (int c = 0; c < 5; c++) begin
            spike_in = (c == 1 || c == 3);
            tick("t5_part");
        end
        idle(12, "t5_abort");
        check("t5_no_valid", 32'(bus.out_valid), 32'd0);
        check("t5_no_ovf",   32'(overflow),      32'd0);
        window_len = 8'd4;
        enable     = 1'b1;
        tick("t5_restart");
        for (int c = 0; c < 4; c++) begin
            spike_in = (c == 2);
            tick("t5_win");
        end
        check("t5_rate", 32'(bus.rate_out), 32'd1);
        check("t5_isi",  32'(bus.isi_out),  32'd0);

        // window_len = 0 keeps the decoder idle; then an ISI spans two windows.
        idle(2, "t6_drain");
        enable     = 1'b1;
        window_len = '0;
        for (int i = 0; i < 6; i++) begin
            tick("t6_zero");
            check("t6_zero_valid", 32'(bus.out_valid), 32'd0);
        end
        window_len = 8'd4;
        tick("t6_start");
        for (int w = 0; w < 2; w++) begin
            for (int c = 0; c < 4; c++) begin
                spike_in = (w == 0) ? (c == 3) : (c == 2);
                tick("t6_win");
            end
        end
        check("t6_isi",  32'(bus.isi_out),  32'd3);
        check("t6_rate", 32'(bus.rate_out), 32'd1);

        // Spikes on every cycle of a window of 20 saturate the 4-bit count.
        idle(2, "t4_idle");
        window_len = 8'd20;
        enable     = 1'b1;
        tick("t4_start");
        spike_in = 1'b1;
        for (int c = 0; c < 20; c++) tick("t4_win");
        check("t4_rate", 32'(bus.rate_out), 32'd15);
        check("t4_sat",  32'(bus.rate_sat), 32'd1);
        check("t4_isi",  32'(bus.isi_out),  32'd1);

        // Consumer stalled: the second result is dropped and overflow sets.
        idle(2, "t3_idle");
        bus.out_ready = 1'b0;
        window_len    = 8'd4;
        enable        = 1'b1;
        tick("t3_start");
        for (int w = 0; w < 2; w++) begin
            for (int c = 0; c < 4; c++) begin
                spike_in = (c == 0);
                tick("t3_win");
            end
            if (w == 0) begin
                check("t3_first_valid", 32'(bus.out_valid), 32'd1);
                check("t3_first_rate",  32'(bus.rate_out),  32'd1);
            end
        end
        check("t3_ovf",       32'(overflow),      32'd1);
        check("t3_held_isi",  32'(bus.isi_out),   32'd0);
        check("t3_held_rate", 32'(bus.rate_out),  32'd1);
        bus.out_ready = 1'b1;
        idle(1, "t3_drain");
        check("t3_drained", 32'(bus.out_valid), 32'd0);
        do_reset();

        // Randomized stretch in phases of spike density and consumer readiness.
        for (int i = 0; i < 3000; i++) begin
            int phase;
            phase  = i / 500;
            enable = ($urandom_range(0, 49) != 0);
            window_len = ($urandom_range(0, 15) == 0) ? '0 : WIN_W'($urandom_range(1, 24));
            case (phase % 3)
                0:       spike_in = ($urandom_range(0, 1) == 1);
                1:       spike_in = ($urandom_range(0, 24) == 0);
                default: spike_in = ($urandom_range(0, 9) != 0);
            endcase
            bus.out_ready = ($urandom_range(0, 9) < ((phase < 3) ? 8 : 3));
            tick("rand");
        end

        // Asynchronous reset in the middle of a window with spikes active.
        bus.out_ready = 1'b0;
        window_len    = 8'd10;
        enable        = 1'b1;
        spike_in      = 1'b1;
        idle(2, "t1_idle");
        enable   = 1'b1;
        spike_in = 1'b1;
        for (int i = 0; i < 14; i++) tick("t1_run");
        reset = 1'b1;
        #2;
        check("t1_async_valid", 32'(bus.out_valid), 32'd0);
        check("t1_async_rate",  32'(bus.rate_out),  32'd0);
        check("t1_async_isi",   32'(bus.isi_out),   32'd0);
        check("t1_async_sat",   32'(bus.rate_sat),  32'd0);
        check("t1_async_ovf",   32'(overflow),      32'd0);
        model_reset();
        @(posedge clk);
        now++;
        #1;
        reset = 1'b0;
        check_outputs("t1_released");
        bus.out_ready = 1'b1;
        window_len    = 8'd3;
        tick("t1_start");
        for (int c = 0; c < 3; c++) tick("t1_win");
        check("t1_rate", 32'(bus.rate_out), 32'd3);
        idle(2, "t1_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
